// File: rtl/bcd_to_binary_if.sv
// Handshake and data bundle for the sequential BCD-to-binary converter.
// The master drives the request and digits; the slave (converter) drives status and result.
interface bcd_to_binary_if #(
    parameter int BIN_W = 10
);
    logic             start;
    logic [3:0]       hundred;
    logic [3:0]       ten;
    logic [3:0]       one;
    logic             busy;
    logic             done;
    logic [BIN_W-1:0] binary_value;
    logic             bcd_err;
    logic             ovf;

    modport master (
        output start, hundred, ten, one,
        input  busy, done, binary_value, bcd_err, ovf
    );

    modport slave (
        input  start, hundred, ten, one,
        output busy, done, binary_value, bcd_err, ovf
    );
endinterface

// File: rtl/bcd_to_binary.sv
// Three-digit BCD to binary converter using reverse double-dabble, one result bit per clock.
// Optional macro BCD_TO_BIN_RANGE8_EN saturates results above 255 to 255 and raises ovf.
module bcd_to_binary #(
    parameter int BIN_W = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    bcd_to_binary_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    localparam int              CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

    state_t           state, state_next;
    logic [11:0]      bcd_q, bcd_next;
    logic [BIN_W-1:0] bin_q, bin_next;
    logic [CNT_W-1:0] count_q, count_next;
    logic [BIN_W-1:0] value_q, value_next;
    logic             err_q, err_next;
    logic             ovf_q, ovf_next;

    logic [11:0]      bcd_shift;
    logic [BIN_W-1:0] bin_shift;
    logic [11:0]      bcd_adj;
    logic             digit_bad;
    logic [BIN_W-1:0] result;
    logic             result_ovf;

    function automatic logic [3:0] adjust(input logic [3:0] d);
        return (d >= 4'd8) ? d - 4'd3 : d;
    endfunction

    // One reverse double-dabble step: shift the whole {bcd,bin} pair right, then fix each digit.
    always_comb begin
        {bcd_shift, bin_shift} = {bcd_q, bin_q} >> 1;
        bcd_adj = {adjust(bcd_shift[11:8]), adjust(bcd_shift[7:4]), adjust(bcd_shift[3:0])};
    end

    assign digit_bad = (bus.hundred > 4'd9) || (bus.ten > 4'd9) || (bus.one > 4'd9);

`ifdef BCD_TO_BIN_RANGE8_EN
    always_comb begin
        result_ovf = (bin_shift > BIN_W'(255));
        result     = result_ovf ? BIN_W'(255) : bin_shift;
    end
`else
    assign result_ovf = 1'b0;
    assign result     = bin_shift;
`endif

    always_comb begin
        // NOTE: every signal written here gets a default first, so no branch can infer a latch.
        state_next = state;
        bcd_next   = bcd_q;
        bin_next   = bin_q;
        count_next = count_q;
        value_next = value_q;
        err_next   = err_q;
        ovf_next   = ovf_q;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    bcd_next   = {bus.hundred, bus.ten, bus.one};
                    bin_next   = '0;
                    count_next = '0;
                    if (digit_bad) begin
                        value_next = '0;
                        err_next   = 1'b1;
                        ovf_next   = 1'b0;
                        state_next = DONE;
                    end else begin
                        state_next = CONV;
                    end
                end
            end
            CONV: begin
                bcd_next   = bcd_adj;
                bin_next   = bin_shift;
                count_next = count_q + 1'b1;
                if (count_q == LAST) begin
                    value_next = result;
                    err_next   = 1'b0;
                    ovf_next   = result_ovf;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_q   <= '0;
            bin_q   <= '0;
            count_q <= '0;
            value_q <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            bcd_q   <= bcd_next;
            bin_q   <= bin_next;
            count_q <= count_next;
            value_q <= value_next;
            err_q   <= err_next;
            ovf_q   <= ovf_next;
        end
    end

    assign bus.busy         = (state == CONV);
    assign bus.done         = (state == DONE);
    assign bus.binary_value = value_q;
    assign bus.bcd_err      = err_q;
    assign bus.ovf          = ovf_q;
endmodule

// File: tb/tb_bcd_to_binary.sv
// Self-checking bench for bcd_to_binary: cycle-level arithmetic model plus directed vectors.
// Build with +define+BCD_TO_BIN_RANGE8_EN to exercise the saturating variant.
module tb_bcd_to_binary;
    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    bcd_to_binary_if #(.BIN_W(10)) bus ();

    bcd_to_binary #(.BIN_W(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Model: value = 100*h + 10*t + o, reported 10 edges after acceptance; bad digits report next edge.
    int         m_left = 0;
    bit         m_done = 0;
    int         m_num  = 0;
    logic [9:0] m_pend = '0;
    bit         m_pend_ovf = 0;
    logic [9:0] m_val  = '0;
    bit         m_err  = 0;
    bit         m_ovf  = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0; m_done = 0; m_val = '0; m_err = 0; m_ovf = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1; m_val = m_pend; m_ovf = m_pend_ovf; m_err = 0;
            end
        end else if (bus.start) begin
            if (bus.hundred > 9 || bus.ten > 9 || bus.one > 9) begin
                m_done = 1; m_val = '0; m_err = 1; m_ovf = 0;
            end else begin
                m_num = 100 * int'(bus.hundred) + 10 * int'(bus.ten) + int'(bus.one);
`ifdef BCD_TO_BIN_RANGE8_EN
                m_pend_ovf = (m_num > 255);
                m_pend     = m_pend_ovf ? 10'd255 : 10'(m_num);
`else
                m_pend_ovf = 0;
                m_pend     = 10'(m_num);
`endif
                m_left = 10;
            end
        end
    end

    always @(negedge clk) begin
        check("busy",  32'(bus.busy),         32'(m_left > 0));
        check("done",  32'(bus.done),         32'(m_done));
        check("value", 32'(bus.binary_value), 32'(m_val));
        check("err",   32'(bus.bcd_err),      32'(m_err));
        check("ovf",   32'(bus.ovf),          32'(m_ovf));
    end

    // One conversion from IDLE; digits are scrambled after the start edge to prove they were captured.
    task automatic run(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                       input logic [9:0] ev, input bit ee, input bit eo, input int elat);
        int n_busy = 0;
        int lat = 0;
        bit seen = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.hundred = h; bus.ten = t; bus.one = o;
        @(negedge clk);
        bus.start = 1'b0;
        bus.hundred = 4'($urandom); bus.ten = 4'($urandom); bus.one = 4'($urandom);
        for (int i = 0; i < 20 && !seen; i++) begin
            if (bus.done) begin
                seen = 1; lat = i;
            end else begin
                if (bus.busy) n_busy++;
                @(negedge clk);
            end
        end
        check("run_timeout", 32'(seen), 32'd1);
        check("run_latency", 32'(lat), 32'(elat));
        check("run_busy_cycles", 32'(n_busy), 32'(elat));
        check("run_value", 32'(bus.binary_value), 32'(ev));
        check("run_err", 32'(bus.bcd_err), 32'(ee));
        check("run_ovf", 32'(bus.ovf), 32'(eo));
    endtask

    task automatic wait_done(output int when);
        bit seen = 0;
        when = -1;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1; when = cyc;
            end
        end
        check("wait_done_timeout", 32'(seen), 32'd1);
    endtask

    initial begin
        int t1, t2, t3;
        rst_n = 1'b0;
        bus.start = 1'b1;
        bus.hundred = 4'($urandom); bus.ten = 4'($urandom); bus.one = 4'($urandom);
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_value", 32'(bus.binary_value), 32'd0);
        check("rst_err", 32'(bus.bcd_err), 32'd0);
        bus.start = 1'b0;
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_value", 32'(bus.binary_value), 32'd0);
        check("idle_done", 32'(bus.done), 32'd0);

        run(4'd1, 4'd2, 4'd3, 10'd123, 0, 0, 10);
        run(4'd0, 4'd0, 4'd0, 10'd0,   0, 0, 10);
        run(4'd2, 4'd5, 4'd5, 10'd255, 0, 0, 10);
`ifdef BCD_TO_BIN_RANGE8_EN
        run(4'd9, 4'd9, 4'd9, 10'd255, 0, 1, 10);
        run(4'd2, 4'd5, 4'd6, 10'd255, 0, 1, 10);
`else
        run(4'd9, 4'd9, 4'd9, 10'd999, 0, 0, 10);
        run(4'd2, 4'd5, 4'd6, 10'd256, 0, 0, 10);
`endif
        run(4'd1, 4'd10, 4'd3, 10'd0, 1, 0, 0);
        run(4'd0, 4'd7, 4'd7, 10'd77, 0, 0, 10);
        run(4'd15, 4'd0, 4'd0, 10'd0, 1, 0, 0);

        // Start held high: back-to-back completions every 12 edges.
        @(negedge clk);
        bus.start = 1'b1; bus.hundred = 4'd4; bus.ten = 4'd5; bus.one = 4'd6;
        wait_done(t1);
        check("cont_value1", 32'(bus.binary_value), 32'd456);
        wait_done(t2);
        check("cont_spacing1", 32'(t2 - t1), 32'd12);
        check("cont_value2", 32'(bus.binary_value), 32'd456);
        repeat (4) @(negedge clk);
        check("cont_mid_busy", 32'(bus.busy), 32'd1);
        bus.hundred = 4'd0; bus.ten = 4'd0; bus.one = 4'd7; bus.start = 1'b0;
        wait_done(t3);
        check("cont_spacing2", 32'(t3 - t2), 32'd12);
        check("cont_value3", 32'(bus.binary_value), 32'd456);

        // Reset in the middle of a conversion aborts it.
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b1; bus.hundred = 4'd1; bus.ten = 4'd2; bus.one = 4'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_busy_before", 32'(bus.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_value", 32'(bus.binary_value), 32'd0);
        check("abort_err", 32'(bus.bcd_err), 32'd0);
        check("abort_ovf", 32'(bus.ovf), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check("abort_no_done", 32'(bus.done), 32'd0);
        end
        run(4'd0, 4'd4, 4'd2, 10'd42, 0, 0, 10);

        // Round trip of every 8-bit value through its decimal digits.
        for (int v = 0; v < 256; v++) begin
            run(4'(v / 100), 4'((v / 10) % 10), 4'(v % 10), 10'(v), 0, 0, 10);
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
